// File: rtl/seg_rx.sv
// seg_rx: oversampling receiver and 7-segment decoder for the serial display stream (sclk/ds/stclk -> nibbles, dp, 32-bit value, error reporting)
module seg_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        ds,
  input  logic        stclk,
  output logic        digit_stb,
  output logic [2:0]  digit_idx,
  output logic [3:0]  digit_val,
  output logic [7:0]  dp,
  output logic [31:0] value,
  output logic        frame_stb,
  output logic        err_stb,
  output logic [1:0]  err_code,
  output logic [15:0] err_cnt
);
  localparam int L = SYNC_STAGES + 2;
  localparam logic [111:0] SEG_TAB = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0f, 7'h20, 7'h24, 7'h4c, 7'h06, 7'h12, 7'h4f, 7'h01
  };
  logic [L-1:0]  sclk_q, ds_q, stclk_q;
  logic [15:0]   sr_q, sr_d;
  logic [4:0]    bcnt_q, bcnt_d;
  logic [31:0]   wbuf_q, wbuf_m, value_q;
  logic [7:0]    seen_q, dp_q;
  logic [2:0]    digit_idx_q, idx;
  logic [3:0]    digit_val_q, nib;
  logic [1:0]    err_code_q, code_d;
  logic [15:0]   err_cnt_q;
  logic          digit_stb_q, frame_stb_q, err_stb_q;
  logic          sh, st, hit, ok, bad, snap;
  // The two extra stages behind the synchronizer hold the last two synced samples for edge detection.
  assign sh = sclk_q[L-2] & ~sclk_q[L-1];
  assign st = stclk_q[L-2] & ~stclk_q[L-1];
  // A shift coinciding with a latch is folded in before the frame is checked.
  assign sr_d = sh ? {ds_q[L-2], sr_q[15:1]} : sr_q;
  assign bcnt_d = (sh && bcnt_q != 5'd31) ? bcnt_q + 5'd1 : bcnt_q;
  always_comb begin
    hit = 1'b0;
    nib = 4'd0;
    idx = 3'd0;
    for (int i = 0; i < 16; i++)
      if (sr_d[7:1] == SEG_TAB[7*i +: 7]) begin
        hit = 1'b1;
        nib = 4'(i);
      end
    for (int i = 0; i < 8; i++)
      if (sr_d[8+i]) idx = 3'(7 - i);
    wbuf_m = wbuf_q;
    wbuf_m[4*idx +: 4] = nib;
  end
  assign code_d = bcnt_d != 5'd16 ? 2'd2 : !$onehot(sr_d[15:8]) ? 2'd1 : !hit ? 2'd3 : 2'd0;
  assign ok = st && code_d == 2'd0;
  assign bad = st && code_d != 2'd0;
  assign snap = ok && idx == 3'd7 && (seen_q | 8'h80) == 8'hff;
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q      <= '0;
      ds_q        <= '0;
      stclk_q     <= '0;
      sr_q        <= '0;
      bcnt_q      <= '0;
      wbuf_q      <= '0;
      seen_q      <= '0;
      dp_q        <= '0;
      value_q     <= '0;
      digit_idx_q <= '0;
      digit_val_q <= '0;
      err_code_q  <= '0;
      err_cnt_q   <= '0;
      digit_stb_q <= 1'b0;
      frame_stb_q <= 1'b0;
      err_stb_q   <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[L-2:0], sclk};
      ds_q        <= {ds_q[L-2:0], ds};
      stclk_q     <= {stclk_q[L-2:0], stclk};
      sr_q        <= sr_d;
      bcnt_q      <= st ? 5'd0 : bcnt_d;
      digit_stb_q <= ok;
      frame_stb_q <= snap;
      err_stb_q   <= bad;
      if (ok) begin
        wbuf_q      <= wbuf_m;
        dp_q[idx]   <= ~sr_d[0];
        seen_q      <= idx == 3'd7 ? 8'h00 : seen_q | (8'h01 << idx);
        digit_idx_q <= idx;
        digit_val_q <= nib;
      end
      if (snap) value_q <= wbuf_m;
      if (bad) begin
        err_code_q <= code_d;
        err_cnt_q  <= err_cnt_q + {15'd0, err_cnt_q != 16'hffff};
      end
    end
  end
  assign digit_stb = digit_stb_q;
  assign digit_idx = digit_idx_q;
  assign digit_val = digit_val_q;
  assign dp        = dp_q;
  assign value     = value_q;
  assign frame_stb = frame_stb_q;
  assign err_stb   = err_stb_q;
  assign err_code  = err_code_q;
  assign err_cnt   = err_cnt_q;
endmodule
